el2_dec_gpr_wb_q: RTL

- Late-writeback queue and pending-destination scoreboard directly upstream of the GPR file's third write port (wen2/waddr2/wd2).
- Tracks non-blocking loads (tagged, out-of-order return) and the single outstanding divide.
- Buffers their results and drains one per cycle into the GPR write port.
- Reports which architectural registers still have a write in flight, so decode can stall dependent reads.

---
 rtl/el2_pkg.sv | 12 +
 rtl/el2_dec_gpr_wb_q_if.sv | 41 ++++
 rtl/el2_dec_wb_fifo.sv | 71 +++++++
 rtl/el2_dec_gpr_wb_q.sv | 84 ++++++++
 4 files changed

// File: rtl/el2_pkg.sv
// el2_pkg: shared types for the GPR late-writeback queue.
package el2_pkg;
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } tag_entry_t;
endpackage

// File: rtl/el2_dec_gpr_wb_q_if.sv
// el2_dec_gpr_wb_q_if: LSU/divider/decode/GPR-port bundle around the writeback queue.
interface el2_dec_gpr_wb_q_if #(
    parameter int NTAGS = 4
);
    localparam int TAGW = $clog2(NTAGS);
    logic            nb_issue_valid;
    logic [TAGW-1:0] nb_issue_tag;
    logic [4:0]      nb_issue_rd;
    logic            nb_ret_valid;
    logic [TAGW-1:0] nb_ret_tag;
    logic            nb_ret_cancel;
    logic [31:0]     nb_ret_data;
    logic            div_issue_valid;
    logic [4:0]      div_issue_rd;
    logic            div_ret_valid;
    logic [31:0]     div_ret_data;
    logic            div_cancel;
    logic [4:0]      raddr0;
    logic [4:0]      raddr1;
    logic [4:0]      rd_chk;
    logic            rs0_busy;
    logic            rs1_busy;
    logic            rd_busy;
    logic            nb_tags_full;
    logic            wb_valid;
    logic [4:0]      wb_addr;
    logic [31:0]     wb_data;

    modport master (
        output nb_issue_valid, nb_issue_tag, nb_issue_rd, nb_ret_valid, nb_ret_tag,
               nb_ret_cancel, nb_ret_data, div_issue_valid, div_issue_rd, div_ret_valid,
               div_ret_data, div_cancel, raddr0, raddr1, rd_chk,
        input  rs0_busy, rs1_busy, rd_busy, nb_tags_full, wb_valid, wb_addr, wb_data
    );
    modport slave (
        input  nb_issue_valid, nb_issue_tag, nb_issue_rd, nb_ret_valid, nb_ret_tag,
               nb_ret_cancel, nb_ret_data, div_issue_valid, div_issue_rd, div_ret_valid,
               div_ret_data, div_cancel, raddr0, raddr1, rd_chk,
        output rs0_busy, rs1_busy, rd_busy, nb_tags_full, wb_valid, wb_addr, wb_data
    );
endinterface

// File: rtl/el2_dec_wb_fifo.sv
// el2_dec_wb_fifo: 2-push/1-pop circular writeback FIFO exposing every slot's rd.
module el2_dec_wb_fifo
    import el2_pkg::*;
#(
    parameter int DEPTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push0,
    input  wb_entry_t             i_d0,
    input  logic                  i_push1,
    input  wb_entry_t             i_d1,
    input  logic                  i_pop,
    output logic                  o_head_vld,
    output wb_entry_t             o_head,
    output logic [DEPTH-1:0]      o_vld,
    output logic [DEPTH-1:0][4:0] o_rd
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t        r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    w_wr1, w_wr2, w_wr_d1;
    logic [CW:0]      w_count_nxt;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_wr1       = nxt(r_wr_ptr);
    assign w_wr2       = nxt(w_wr1);
    // a lone divide push takes the current write slot, otherwise it lands behind the load
    assign w_wr_d1     = i_push0 ? w_wr1 : r_wr_ptr;
    assign w_count_nxt = {1'b0, r_count} + (CW+1)'(i_push0) + (CW+1)'(i_push1) - (CW+1)'(i_pop);
    assign o_head_vld  = r_vld[r_rd_ptr];
    assign o_head      = r_mem[r_rd_ptr];
    assign o_vld       = r_vld;

    for (genvar g = 0; g < DEPTH; g++) begin : g_rd
        assign o_rd[g] = r_mem[g].rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld    <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= nxt(r_rd_ptr);
            end
            if (i_push0) begin
                r_mem[r_wr_ptr] <= i_d0;
                r_vld[r_wr_ptr] <= 1'b1;
            end
            if (i_push1) begin
                r_mem[w_wr_d1] <= i_d1;
                r_vld[w_wr_d1] <= 1'b1;
            end
            r_wr_ptr <= (i_push0 && i_push1) ? w_wr2 : (i_push0 || i_push1) ? w_wr1 : r_wr_ptr;
            r_count  <= w_count_nxt[CW-1:0];
        end
    end

    assert property (@(posedge clk) disable iff (rst) w_count_nxt <= (CW+1)'(DEPTH));
endmodule

// File: rtl/el2_dec_gpr_wb_q.sv
// el2_dec_gpr_wb_q: late-writeback queue and pending-destination scoreboard feeding GPR write port 2.
module el2_dec_gpr_wb_q
    import el2_pkg::*;
#(
    parameter int NTAGS = 4
) (
    input logic               clk,
    input logic               rst,
    el2_dec_gpr_wb_q_if.slave bus
);
    localparam int DEPTH = NTAGS + 1;

    tag_entry_t [NTAGS-1:0] r_tags;
    logic                   r_div_pend;
    logic [4:0]             r_div_rd;
    logic                   w_ret_hit, w_push0, w_push1, w_head_vld;
    wb_entry_t              w_d0, w_d1, w_head;
    logic [DEPTH-1:0]       w_fifo_vld;
    logic [DEPTH-1:0][4:0]  w_fifo_rd;
    logic [NTAGS-1:0]       w_tag_vld;
    logic [31:0]            w_pend;

    assign w_ret_hit = bus.nb_ret_valid && r_tags[bus.nb_ret_tag].valid;
    assign w_push0   = w_ret_hit && !bus.nb_ret_cancel && (r_tags[bus.nb_ret_tag].rd != 5'd0);
    assign w_push1   = r_div_pend && bus.div_ret_valid && !bus.div_cancel && (r_div_rd != 5'd0);
    assign w_d0      = '{rd: r_tags[bus.nb_ret_tag].rd, data: bus.nb_ret_data};
    assign w_d1      = '{rd: r_div_rd, data: bus.div_ret_data};

    // return is applied before issue so a same-cycle reissue of the tag/slot survives
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tags     <= '0;
            r_div_pend <= 1'b0;
            r_div_rd   <= '0;
        end else begin
            if (w_ret_hit) r_tags[bus.nb_ret_tag].valid <= 1'b0;
            if (bus.nb_issue_valid) r_tags[bus.nb_issue_tag] <= '{valid: 1'b1, rd: bus.nb_issue_rd};
            if (bus.div_cancel || bus.div_ret_valid) r_div_pend <= 1'b0;
            if (bus.div_issue_valid) begin
                r_div_pend <= 1'b1;
                r_div_rd   <= bus.div_issue_rd;
            end
        end
    end

    el2_dec_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push0   (w_push0),
        .i_d0      (w_d0),
        .i_push1   (w_push1),
        .i_d1      (w_d1),
        .i_pop     (w_head_vld),
        .o_head_vld(w_head_vld),
        .o_head    (w_head),
        .o_vld     (w_fifo_vld),
        .o_rd      (w_fifo_rd)
    );

    for (genvar g = 0; g < NTAGS; g++) begin : g_tv
        assign w_tag_vld[g] = r_tags[g].valid;
    end

    // one bit per architectural register with a write still in flight; x0 never pends
    always_comb begin
        w_pend = '0;
        for (int i = 0; i < NTAGS; i++) if (r_tags[i].valid) w_pend[r_tags[i].rd] = 1'b1;
        if (r_div_pend) w_pend[r_div_rd] = 1'b1;
        for (int i = 0; i < DEPTH; i++) if (w_fifo_vld[i]) w_pend[w_fifo_rd[i]] = 1'b1;
        w_pend[0] = 1'b0;
    end

    assign bus.rs0_busy     = w_pend[bus.raddr0];
    assign bus.rs1_busy     = w_pend[bus.raddr1];
    assign bus.rd_busy      = w_pend[bus.rd_chk];
    assign bus.nb_tags_full = &w_tag_vld;
    assign bus.wb_valid     = w_head_vld;
    assign bus.wb_addr      = w_head_vld ? w_head.rd : 5'd0;
    assign bus.wb_data      = w_head_vld ? w_head.data : 32'd0;

    assert property (@(posedge clk) disable iff (rst) bus.nb_ret_valid |-> w_ret_hit);
    assert property (@(posedge clk) disable iff (rst)
        (bus.div_issue_valid && r_div_pend) |-> (bus.div_ret_valid || bus.div_cancel));
endmodule
